// File: rtl/mdsa_stream_adapter_if.sv
// Bundle of every handshake/bus signal between the MDSA stream adapter,
// the host streams and the sorter controller.
//   slave  : adapter side (consumes in_*, produces out_*, drives sort_*)
//   master : host/sorter side (the opposite directions)
// Keys are packed with slot k at [k*DATA_W +: DATA_W] on load_data/sorted_data.
interface mdsa_stream_adapter_if #(
  parameter int DATA_W = 8,
  parameter int N_ELEM = 9
);
  logic [DATA_W-1:0]        in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     sort_start;
  logic                     sort_en;
  logic                     sort_ready;
  logic                     sort_oe;
  logic [N_ELEM*DATA_W-1:0] load_data;
  logic [N_ELEM*DATA_W-1:0] sorted_data;
  logic                     busy;
  logic                     err;

  modport slave (
    input  in_data, in_valid, out_ready, sort_ready, sort_oe, sorted_data,
    output in_ready, out_data, out_valid, out_last, sort_start, sort_en,
           load_data, busy, err
  );

  modport master (
    output in_data, in_valid, out_ready, sort_ready, sort_oe, sorted_data,
    input  in_ready, out_data, out_valid, out_last, sort_start, sort_en,
           load_data, busy, err
  );
endinterface

// File: rtl/mdsa_stream_adapter.sv
// Host-side adapter for the MDSA sort controller.
// Collects N_ELEM keys from the input stream into a buffer that drives the
// sorter's parallel load bus, pulses START, waits (with watchdog) for the
// sorter's output_enable, captures the sorted result and replays it on the
// output stream, slot 0 first.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - mdsa_stream_adapter_if.slave: input stream, output stream,
//          sorter handshake (start/en/ready/oe), load/sorted buses, busy, err
// Every output is a flop or a decode of state/idx/buffer; no input reaches
// an output combinationally.
module mdsa_stream_adapter #(
  parameter int DATA_W  = 8,
  parameter int N_ELEM  = 9,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  mdsa_stream_adapter_if.slave  bus
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEM - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FILL, S_ARM, S_LAUNCH, S_BUSY, S_DRAIN
  } state_t;

  state_t                           state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic [WD_W-1:0]                  wd_q, wd_d;
  logic [N_ELEM-1:0][DATA_W-1:0]    buf_q, buf_d;
  logic                             sort_start_q, sort_start_d;
  logic                             sort_en_q, sort_en_d;
  logic                             err_q, err_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wd_d         = wd_q;
    buf_d        = buf_q;
    sort_start_d = 1'b0;
    sort_en_d    = 1'b1;
    err_d        = 1'b0;
    case (state_q)
      S_FILL: begin
        if (bus.in_valid) begin
          buf_d[idx_q] = bus.in_data;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_ARM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_ARM: begin
        // START is registered so it is high exactly while in LAUNCH.
        if (bus.sort_ready) begin
          state_d      = S_LAUNCH;
          sort_start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // Hold at WD_LAST rather than wrap; the state always exits there.
        if (wd_q != WD_LAST) wd_d = wd_q + 1'b1;
        if (bus.sort_oe) begin
          buf_d   = bus.sorted_data;
          idx_d   = '0;
          state_d = S_DRAIN;
        end else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = S_FILL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_FILL;
      idx_q        <= '0;
      wd_q         <= '0;
      buf_q        <= '0;
      sort_start_q <= 1'b0;
      sort_en_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wd_q         <= wd_d;
      buf_q        <= buf_d;
      sort_start_q <= sort_start_d;
      sort_en_q    <= sort_en_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_ready   = (state_q == S_FILL);
  assign bus.out_valid  = (state_q == S_DRAIN);
  assign bus.out_data   = buf_q[idx_q];
  assign bus.out_last   = (state_q == S_DRAIN) && (idx_q == IDX_LAST);
  assign bus.sort_start = sort_start_q;
  assign bus.sort_en    = sort_en_q;
  assign bus.load_data  = buf_q;
  assign bus.busy       = (state_q == S_ARM) || (state_q == S_LAUNCH) ||
                          (state_q == S_BUSY);
  assign bus.err        = err_q;

endmodule

// File: tb/tb_mdsa_stream_adapter.sv
// Directed bench for mdsa_stream_adapter (DATA_W=8, N_ELEM=9, TIMEOUT=16).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_mdsa_stream_adapter;
  localparam int DW = 8;
  localparam int NE = 9;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nfail = 0;
  int   start_cnt = 0;
  int   err_cnt = 0;

  mdsa_stream_adapter_if #(.DATA_W(DW), .N_ELEM(NE)) bus ();

  mdsa_stream_adapter #(.DATA_W(DW), .N_ELEM(NE), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.sort_start === 1'b1) start_cnt <= start_cnt + 1;
    if (bus.err === 1'b1)        err_cnt   <= err_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] k);
    bit acc;
    int g;
    bus.in_data  = k;
    bus.in_valid = 1'b1;
    g = 0;
    do begin
      acc = bus.in_ready;
      tick();
      g++;
    end while (!acc && g < 50);
    if (!acc) chk("in_accept_timeout", acc, 1);
  endtask

  // n keys: k0, k0+step, ... ; optional idle cycle after each key
  task automatic fill(input logic [7:0] k0, input int step, input bit gaps,
                      input int n);
    for (int j = 0; j < n; j++) begin
      send_key(8'(int'(k0) + j * step));
      if (gaps) begin
        bus.in_valid = 1'b0;
        tick();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int g;
    g = 0;
    while (bus.sort_start !== 1'b1 && g < 100) begin
      tick();
      g++;
    end
    chk("start_seen", bus.sort_start, 1);
  endtask

  // sorted slot k = s0+k; output_enable pulse after dly cycles
  task automatic sorter(input int dly, input logic [7:0] s0);
    for (int k = 0; k < NE; k++) bus.sorted_data[k*DW +: DW] = 8'(s0 + k);
    repeat (dly) tick();
    bus.sort_oe = 1'b1;
    tick();
    bus.sort_oe = 1'b0;
  endtask

  // mode 0: out_ready always 1; mode 1: ready 1 cycle, 0 for 2, repeating
  task automatic drain(input logic [7:0] s0, input int mode, input int nout);
    int j;
    int ph;
    int g;
    j = 0; ph = 0; g = 0;
    while (j < nout && g < 200) begin
      bus.out_ready = (mode == 0) || (ph % 3 == 0);
      ph++;
      if (bus.out_valid) begin
        chk("out_data", bus.out_data, 8'(s0 + j));
        if (bus.out_ready) begin
          chk("out_last", bus.out_last, (j == NE - 1));
          j++;
        end
      end
      tick();
      g++;
    end
    bus.out_ready = 1'b0;
    chk("drain_count", j, nout);
  endtask

  initial begin
    bit bad;
    rst = 1'b1;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.sort_ready = 1'b1; bus.sort_oe = 1'b0; bus.sorted_data = '0;
    repeat (3) tick();

    // reset state
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_sort_start", bus.sort_start, 0);
    chk("rst_sort_en", bus.sort_en, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_load", bus.load_data, 0);
    rst = 1'b0;
    tick();
    chk("sort_en_on", bus.sort_en, 1);

    // basic job, sort_ready already high: start 2 cycles after last key
    fill(8'd9, -1, 1'b0, NE);
    chk("t1_arm_in_ready", bus.in_ready, 0);
    chk("t1_arm_busy", bus.busy, 1);
    chk("t1_arm_start", bus.sort_start, 0);
    chk("t1_load_slot0", bus.load_data[7:0], 8'd9);
    chk("t1_load_slot8", bus.load_data[71:64], 8'd1);
    tick();
    chk("t1_start", bus.sort_start, 1);
    sorter(12, 8'd1);
    chk("t1_drain_valid", bus.out_valid, 1);
    drain(8'd1, 0, NE);
    chk("t1_back_to_fill", bus.in_ready, 1);
    chk("t1_starts", start_cnt, 1);

    // gapped input, out_ready 1-0-0 back-pressure
    fill(8'h11, 8'h11, 1'b1, NE);
    chk("t2_load", bus.load_data, 72'h998877665544332211);
    wait_start();
    sorter(3, 8'hA0);
    drain(8'hA0, 1, NE);

    // launch hold-off while sort_ready low
    bus.sort_ready = 1'b0;
    fill(8'h21, 1, 1'b0, NE);
    bad = 1'b0;
    repeat (20) begin
      if (bus.in_ready !== 1'b0 || bus.sort_start !== 1'b0) bad = 1'b1;
      tick();
    end
    chk("t3_holdoff", bad, 0);
    bus.sort_ready = 1'b1;
    tick();
    chk("t3_start_after_ready", bus.sort_start, 1);
    tick();
    chk("t3_start_one_cycle", bus.sort_start, 0);
    sorter(2, 8'h30);
    drain(8'h30, 0, NE);

    // watchdog: 16 BUSY cycles, err registered on the FILL re-entry cycle
    fill(8'h40, 1, 1'b0, NE);
    wait_start();
    bad = 1'b0;
    repeat (16) begin
      tick();
      if (bus.err !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
    end
    chk("t4_no_early_err", bad, 0);
    tick();
    chk("t4_err", bus.err, 1);
    chk("t4_in_ready", bus.in_ready, 1);
    chk("t4_out_valid", bus.out_valid, 0);
    chk("t4_busy", bus.busy, 0);
    tick();
    chk("t4_err_pulse", bus.err, 0);
    fill(8'h50, 3, 1'b0, NE);
    chk("t4_next_slot0", bus.load_data[7:0], 8'h50);
    wait_start();
    sorter(5, 8'h60);
    drain(8'h60, 0, NE);

    // spurious oe in FILL; oe coincident with the timeout cycle
    fill(8'h71, 1, 1'b0, 4);
    for (int k = 0; k < NE; k++) bus.sorted_data[k*DW +: DW] = 8'hEE;
    bus.sort_oe = 1'b1;
    tick();
    bus.sort_oe = 1'b0;
    chk("t5_fill_in_ready", bus.in_ready, 1);
    chk("t5_fill_out_valid", bus.out_valid, 0);
    fill(8'h75, 1, 1'b0, 5);
    chk("t5_slot0", bus.load_data[7:0], 8'h71);
    chk("t5_slot4", bus.load_data[39:32], 8'h75);
    wait_start();
    sorter(16, 8'h70);
    chk("t5_coinc_err", bus.err, 0);
    chk("t5_coinc_valid", bus.out_valid, 1);
    drain(8'h70, 0, NE);

    // async reset after 4 outputs
    fill(8'h01, 1, 1'b0, NE);
    wait_start();
    sorter(1, 8'h80);
    drain(8'h80, 0, 4);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", bus.out_valid, 0);
    chk("t6_rst_in_ready", bus.in_ready, 1);
    chk("t6_rst_start", bus.sort_start, 0);
    chk("t6_rst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();
    fill(8'hC1, 1, 1'b0, NE);
    chk("t6_slot0", bus.load_data[7:0], 8'hC1);
    wait_start();
    sorter(1, 8'h90);
    drain(8'h90, 0, NE);

    tick();
    chk("total_starts", start_cnt, 8);
    chk("total_errs", err_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
